// File: rtl/barrelshifter_pipe_if.sv
// Stream bundle for the pipelined barrel shifter: operand/mode/coeff in, result/flags out.
// The slave modport is the shifter's view; master is the producer/consumer side.
interface barrelshifter_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             rx_valid;
  logic             rx_ready;
  logic [2:0]       rx_mode;
  logic [WIDTH-1:0] rx_input;
  logic [SHW-1:0]   rx_coeff;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_shift;
  logic             tx_carry;
  logic             tx_zero;

  modport master (
    output rx_valid, rx_mode, rx_input, rx_coeff, tx_ready,
    input  rx_ready, tx_valid, tx_shift, tx_carry, tx_zero
  );

  modport slave (
    input  rx_valid, rx_mode, rx_input, rx_coeff, tx_ready,
    output rx_ready, tx_valid, tx_shift, tx_carry, tx_zero
  );
endinterface

// File: rtl/barrelshifter_pipe.sv
// Pipelined barrel shifter (PASS/SLL/SRL/SRA/ROL/ROR), capture + SHW shift stages + output, latency SHW+2 edges.
// Single global stall when the output is held (tx_valid & ~tx_ready); bubbles are kept, rx_ready = ~stall.
module barrelshifter_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic                aclk,
  input  logic                areset,
  barrelshifter_pipe_if.slave bus
);
  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_SLL  = 3'b001;
  localparam logic [2:0] MODE_SRL  = 3'b010;
  localparam logic [2:0] MODE_SRA  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  typedef struct packed {
    logic             vld;
    logic [2:0]       mode;
    logic [WIDTH-1:0] dat;
    logic [SHW-1:0]   coeff;
    logic             carry;
  } stage_t;

  stage_t           cap;
  stage_t           pipe [SHW+1];
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             out_carry;
  logic             out_zero;
  logic             stall;

  assign stall        = out_vld & ~bus.tx_ready;
  assign bus.rx_ready = ~stall;
  assign bus.tx_valid = out_vld;
  assign bus.tx_shift = out_dat;
  assign bus.tx_carry = out_carry;
  assign bus.tx_zero  = out_zero;

  // Zero shifts and unknown modes collapse to PASS so later stages and carry logic never see them.
  always_comb begin
    cap       = '0;
    cap.vld   = bus.rx_valid;
    cap.dat   = bus.rx_input;
    cap.coeff = bus.rx_coeff;
    cap.mode  = (bus.rx_mode > MODE_ROR || bus.rx_coeff == '0) ? MODE_PASS : bus.rx_mode;
    case (cap.mode)
      MODE_SLL:           cap.carry = bus.rx_input[SHW'(0) - bus.rx_coeff];
      MODE_SRL, MODE_SRA: cap.carry = bus.rx_input[bus.rx_coeff - SHW'(1)];
      default:            cap.carry = 1'b0;
    endcase
  end

  function automatic stage_t shift_stage(input stage_t s, input int k);
    stage_t r   = s;
    int     amt = 1 << k;
    if (s.coeff[k]) begin
      case (s.mode)
        MODE_SLL: r.dat = s.dat << amt;
        MODE_SRL: r.dat = s.dat >> amt;
        MODE_SRA: r.dat = $signed(s.dat) >>> amt;
        MODE_ROL: r.dat = (s.dat << amt) | (s.dat >> (WIDTH - amt));
        MODE_ROR: r.dat = (s.dat >> amt) | (s.dat << (WIDTH - amt));
        default:  r.dat = s.dat;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i <= SHW; i++) pipe[i] <= '0;
      out_vld   <= 1'b0;
      out_dat   <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (!stall) begin
      pipe[0] <= cap;
      for (int k = 0; k < SHW; k++) pipe[k+1] <= shift_stage(pipe[k], k);
      out_vld  <= pipe[SHW].vld;
      out_dat  <= pipe[SHW].dat;
      out_zero <= (pipe[SHW].dat == '0);
      // Rotate carry comes from the finished result; shift carries were resolved at capture.
      case (pipe[SHW].mode)
        MODE_ROL: out_carry <= pipe[SHW].dat[0];
        MODE_ROR: out_carry <= pipe[SHW].dat[WIDTH-1];
        default:  out_carry <= pipe[SHW].carry;
      endcase
    end
  end
endmodule

// File: tb/tb_barrelshifter_pipe.sv
// Self-checking bench for barrelshifter_pipe at WIDTH=16: directed vectors plus random streams
// compared against a direct arithmetic model of the shift/rotate rules.
module tb_barrelshifter_pipe;
  localparam int W   = 16;
  localparam int SW  = 4;
  localparam int LAT = SW + 1;

  logic aclk;
  logic areset;
  int   n_vec = 0;
  int   n_err = 0;

  barrelshifter_pipe_if #(.WIDTH(W)) bus ();
  barrelshifter_pipe #(.WIDTH(W)) dut (.aclk(aclk), .areset(areset), .bus(bus));

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic void model(input logic [2:0] m, input logic [W-1:0] x, input int s,
                                output logic [W-1:0] r, output logic c);
    logic [2*W-1:0] dbl;
    dbl = {x, x};
    r   = x;
    c   = 1'b0;
    if (s != 0) begin
      case (m)
        3'd1: begin r = x << s; c = x[W-s]; end
        3'd2: begin r = x >> s; c = x[s-1]; end
        3'd3: begin r = $signed(x) >>> s; c = x[s-1]; end
        3'd4: begin dbl = dbl << s; r = dbl[2*W-1:W]; c = r[0]; end
        3'd5: begin dbl = dbl >> s; r = dbl[W-1:0]; c = r[W-1]; end
        default: begin r = x; c = 1'b0; end
      endcase
    end
  endfunction

  // Sends one beat into an idle pipe with tx_ready high and reports when and what came out.
  task automatic send_one(input logic [2:0] m, input logic [W-1:0] x, input logic [SW-1:0] s,
                          output int lat, output logic [W-1:0] r, output logic c, output logic z);
    bus.tx_ready = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_mode  = m;
    bus.rx_input = x;
    bus.rx_coeff = s;
    tick();
    bus.rx_valid = 1'b0;
    lat = -1;
    r   = '0;
    c   = 1'b0;
    z   = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.tx_valid) begin
        lat = i;
        r   = bus.tx_shift;
        c   = bus.tx_carry;
        z   = bus.tx_zero;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    int seen;
    areset       = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_mode  = 3'b001;
    bus.rx_input = 16'($urandom);
    bus.rx_coeff = 4'd3;
    bus.tx_ready = 1'b1;
    repeat (2) tick();
    n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    n_vec++; if (bus.tx_shift !== '0)   begin n_err++; $display("FAIL reset_tx_shift: got %h want 0000", bus.tx_shift); end
    n_vec++; if (bus.tx_carry !== 1'b0) begin n_err++; $display("FAIL reset_tx_carry: got %b want 0", bus.tx_carry); end
    n_vec++; if (bus.tx_zero !== 1'b0)  begin n_err++; $display("FAIL reset_tx_zero: got %b want 0", bus.tx_zero); end
    n_vec++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
    areset       = 1'b0;
    bus.rx_valid = 1'b0;
    seen = 0;
    repeat (LAT + 4) begin
      tick();
      if (bus.tx_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL reset_no_output: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_mode_sweep();
    logic [2:0]   modes [6];
    logic [W-1:0] exp_r [6];
    int lat; logic [W-1:0] r; logic c, z;
    modes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_r = '{16'h4210, 16'h0842, 16'hF842, 16'h4218, 16'h1842, 16'h8421};
    for (int i = 0; i < 6; i++) begin
      send_one(modes[i], 16'h8421, 4'd4, lat, r, c, z);
      n_vec++; if (lat !== LAT)     begin n_err++; $display("FAIL sweep_latency mode %0d: got %0d want %0d", modes[i], lat, LAT); end
      n_vec++; if (r !== exp_r[i])  begin n_err++; $display("FAIL sweep_result mode %0d: got %h want %h", modes[i], r, exp_r[i]); end
      n_vec++; if (c !== 1'b0)      begin n_err++; $display("FAIL sweep_carry mode %0d: got %b want 0", modes[i], c); end
      n_vec++; if (z !== 1'b0)      begin n_err++; $display("FAIL sweep_zero mode %0d: got %b want 0", modes[i], z); end
    end
  endtask

  task automatic test_boundaries();
    logic [2:0]    bm [3];
    logic [W-1:0]  bx [3];
    logic [SW-1:0] bs [3];
    logic [W-1:0]  br [3];
    logic          bc [3];
    logic          bz [3];
    int lat; logic [W-1:0] r; logic c, z;
    bm = '{3'd1, 3'd1, 3'd3};
    bx = '{16'h0001, 16'h8000, 16'h8000};
    bs = '{4'd15, 4'd1, 4'd15};
    br = '{16'h8000, 16'h0000, 16'hFFFF};
    bc = '{1'b0, 1'b1, 1'b0};
    bz = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_one(bm[i], bx[i], bs[i], lat, r, c, z);
      n_vec++; if (r !== br[i] || c !== bc[i] || z !== bz[i] || lat !== LAT) begin
        n_err++; $display("FAIL boundary_%0d: got r=%h c=%b z=%b lat=%0d want r=%h c=%b z=%b lat=%0d",
                          i, r, c, z, lat, br[i], bc[i], bz[i], LAT);
      end
    end
    for (int m = 0; m < 8; m++) begin
      send_one(3'(m), 16'hA5A5, 4'd0, lat, r, c, z);
      n_vec++; if (r !== 16'hA5A5 || c !== 1'b0 || z !== 1'b0) begin
        n_err++; $display("FAIL zero_shift mode %0d: got r=%h c=%b z=%b want r=a5a5 c=0 z=0", m, r, c, z);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q_r[$];
    logic         q_c[$];
    int sent = 0, got = 0;
    logic held_vld = 1'b0;
    logic [W+1:0] held = '0;
    logic [2:0] m; logic [W-1:0] x; logic [SW-1:0] s; logic [W-1:0] er; logic ec;
    m = 3'($urandom); x = 16'($urandom); s = 4'($urandom);
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      if (held_vld) begin
        n_vec++; if (bus.tx_valid !== 1'b1 || {bus.tx_shift, bus.tx_carry, bus.tx_zero} !== held) begin
          n_err++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", bus.tx_valid,
                            {bus.tx_shift, bus.tx_carry, bus.tx_zero}, held);
        end
      end
      bus.tx_ready = 1'($urandom_range(0, 1));
      bus.rx_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      bus.rx_mode  = m;
      bus.rx_input = x;
      bus.rx_coeff = s;
      #1;
      n_vec++; if (bus.rx_ready !== !(bus.tx_valid && !bus.tx_ready)) begin
        n_err++; $display("FAIL bp_rx_ready: got %b want %b", bus.rx_ready, !(bus.tx_valid && !bus.tx_ready));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        n_vec++;
        if (q_r.size() == 0) begin
          n_err++; $display("FAIL bp_extra: got unexpected beat %h want none", bus.tx_shift);
        end else begin
          er = q_r.pop_front();
          ec = q_c.pop_front();
          if ({bus.tx_shift, bus.tx_carry, bus.tx_zero} !== {er, ec, er == '0}) begin
            n_err++; $display("FAIL bp_data beat %0d: got %h/%b/%b want %h/%b/%b", got,
                              bus.tx_shift, bus.tx_carry, bus.tx_zero, er, ec, er == '0);
          end
          got++;
        end
      end
      held_vld = bus.tx_valid && !bus.tx_ready;
      held     = {bus.tx_shift, bus.tx_carry, bus.tx_zero};
      if (bus.rx_valid && bus.rx_ready) begin
        model(m, x, int'(s), er, ec);
        q_r.push_back(er);
        q_c.push_back(ec);
        sent++;
        m = 3'($urandom); x = 16'($urandom); s = 4'($urandom);
      end
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    n_vec++; if (got !== 20 || q_r.size() !== 0) begin
      n_err++; $display("FAIL bp_count: got %0d beats (%0d pending) want 20 (0 pending)", got, q_r.size());
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    int lat; logic [W-1:0] r, er; logic c, z, ec;
    logic [2:0] m; logic [W-1:0] x; logic [SW-1:0] s;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_mode  = 3'($urandom_range(0, 5));
      bus.rx_input = 16'($urandom);
      bus.rx_coeff = 4'($urandom);
      tick();
    end
    bus.rx_valid = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    repeat (LAT + 6) begin
      tick();
      if (bus.tx_valid) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midreset_flush: got %0d valid cycles want 0", seen); end
    m = 3'($urandom_range(1, 5)); x = 16'($urandom); s = 4'($urandom_range(1, 15));
    model(m, x, int'(s), er, ec);
    send_one(m, x, s, lat, r, c, z);
    n_vec++; if (lat !== LAT || r !== er || c !== ec) begin
      n_err++; $display("FAIL midreset_next: got lat=%0d r=%h c=%b want lat=%0d r=%h c=%b", lat, r, c, LAT, er, ec);
    end
  endtask

  task automatic test_throughput();
    logic [W-1:0] q_r[$];
    logic         q_c[$];
    int sent = 0, nvalid = 0, first = -1, last = -1;
    logic [W-1:0] er; logic ec;
    bus.tx_ready = 1'b1;
    for (int cyc = 0; cyc < 32 + LAT + 6; cyc++) begin
      bus.rx_valid = (cyc < 32);
      bus.rx_mode  = 3'($urandom);
      bus.rx_input = 16'($urandom);
      bus.rx_coeff = 4'($urandom);
      #1;
      if (bus.tx_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        nvalid++;
        n_vec++;
        if (q_r.size() == 0) begin
          n_err++; $display("FAIL tput_extra: got beat %h want none", bus.tx_shift);
        end else begin
          er = q_r.pop_front();
          ec = q_c.pop_front();
          if (bus.tx_shift !== er || bus.tx_carry !== ec) begin
            n_err++; $display("FAIL tput_data: got %h/%b want %h/%b", bus.tx_shift, bus.tx_carry, er, ec);
          end
        end
      end
      if (bus.rx_valid && bus.rx_ready) begin
        model(bus.rx_mode, bus.rx_input, int'(bus.rx_coeff), er, ec);
        q_r.push_back(er);
        q_c.push_back(ec);
        sent++;
      end
      tick();
    end
    bus.rx_valid = 1'b0;
    n_vec++; if (sent !== 32) begin n_err++; $display("FAIL tput_accept: got %0d accepted want 32", sent); end
    n_vec++; if (nvalid !== 32 || (last - first + 1) !== 32) begin
      n_err++; $display("FAIL tput_run: got %0d valid over span %0d want 32 over 32", nvalid, last - first + 1);
    end
  endtask

  initial begin
    areset       = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_mode  = '0;
    bus.rx_input = '0;
    bus.rx_coeff = '0;
    bus.tx_ready = 1'b1;
    test_reset();
    test_mode_sweep();
    test_boundaries();
    test_backpressure();
    test_reset_midstream();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
